// File: rtl/elink_rx_distributor_if.sv
// elink_rx_distributor_if
// Bundles the e-link receive word stream and the four-channel CAN-side
// distribution outputs of elink_rx_distributor.
//   data_rx_in[9:0]   received word, [9:8] kind, [7:0] byte
//   data_rx_valid     qualifier for data_rx_in
//   Kchar_comma[7:0]  comma byte used as idle filler and lock pattern
//   data_out[7:0]     payload byte shared by all channels
//   data_valid[3:0]   one-hot channel strobe for data_out
//   frame_end[3:0]    one-hot end-of-frame pulse
//   frame_err         protocol error pulse
//   locked            word lock held
//   err_count[7:0]    saturating error counter (only with ELINK_RX_ERRCNT_EN)
// master: the word source (deserializer side); slave: the distributor.
interface elink_rx_distributor_if;
    logic [9:0] data_rx_in;
    logic       data_rx_valid;
    logic [7:0] Kchar_comma;
    logic [7:0] data_out;
    logic [3:0] data_valid;
    logic [3:0] frame_end;
    logic       frame_err;
    logic       locked;
`ifdef ELINK_RX_ERRCNT_EN
    logic [7:0] err_count;

    modport master (
        output data_rx_in, data_rx_valid, Kchar_comma,
        input  data_out, data_valid, frame_end, frame_err, locked, err_count
    );
    modport slave (
        input  data_rx_in, data_rx_valid, Kchar_comma,
        output data_out, data_valid, frame_end, frame_err, locked, err_count
    );
`else
    modport master (
        output data_rx_in, data_rx_valid, Kchar_comma,
        input  data_out, data_valid, frame_end, frame_err, locked
    );
    modport slave (
        input  data_rx_in, data_rx_valid, Kchar_comma,
        output data_out, data_valid, frame_end, frame_err, locked
    );
`endif
endinterface

// File: rtl/elink_rx_distributor.sv
// elink_rx_distributor
// Receive side of the four-channel e-link link. Acquires word lock on a run
// of LOCK_CNT comma words, parses SOP/data/EOP framing and steers payload
// bytes to one of four CAN channels with one-hot strobes. All outputs are
// registered; only words with data_rx_valid high advance the logic.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-low reset
//   bus   elink_rx_distributor_if.slave (word input, channel outputs)
// Optional feature: define ELINK_RX_ERRCNT_EN to add the saturating
// err_count[7:0] output counting frame_err pulses.
module elink_rx_distributor #(
    parameter int LOCK_CNT = 4,
    parameter int MAX_LEN  = 16
) (
    input logic                  clk,
    input logic                  rst,
    elink_rx_distributor_if.slave bus
);

    localparam int CW = $clog2(MAX_LEN + 1);
    localparam logic [3:0]    LOCK_LAST = 4'(LOCK_CNT - 1);
    localparam logic [CW-1:0] LEN_MAX   = CW'(MAX_LEN);

    localparam logic [1:0] KIND_DATA = 2'b00;
    localparam logic [1:0] KIND_SOP  = 2'b01;
    localparam logic [1:0] KIND_EOP  = 2'b10;
    localparam logic [1:0] KIND_K    = 2'b11;

    typedef enum logic [1:0] {UNLOCKED, IDLE, FRAME} state_t;

    state_t        state_q, state_d;
    logic [3:0]    commaCnt_q, commaCnt_d;
    logic [CW-1:0] byteCnt_q, byteCnt_d;
    logic [1:0]    channel_q, channel_d;
    logic [7:0]    dataOut_q, dataOut_d;
    logic [3:0]    dataValid_q, dataValid_d;
    logic [3:0]    frameEnd_q, frameEnd_d;
    logic          frameErr_q, frameErr_d;
    logic          locked_q, locked_d;

    logic [1:0] kind;
    logic [7:0] rxByte;
    logic       isComma;

    assign kind    = bus.data_rx_in[9:8];
    assign rxByte  = bus.data_rx_in[7:0];
    assign isComma = (kind == KIND_K) && (rxByte == bus.Kchar_comma);

    // Next-state and output decode. Strobes default low so they are single
    // cycle pulses and stay low on cycles without a valid word; data_out
    // holds its last payload byte between strobes.
    always_comb begin
        state_d     = state_q;
        commaCnt_d  = commaCnt_q;
        byteCnt_d   = byteCnt_q;
        channel_d   = channel_q;
        dataOut_d   = dataOut_q;
        dataValid_d = 4'b0000;
        frameEnd_d  = 4'b0000;
        frameErr_d  = 1'b0;
        if (bus.data_rx_valid) begin
            case (state_q)
                UNLOCKED: begin
                    // Any non-comma word breaks the run without flagging an error.
                    if (isComma) begin
                        if (commaCnt_q == LOCK_LAST) begin
                            state_d    = IDLE;
                            commaCnt_d = 4'd0;
                        end else begin
                            commaCnt_d = commaCnt_q + 4'd1;
                        end
                    end else begin
                        commaCnt_d = 4'd0;
                    end
                end
                IDLE: begin
                    case (kind)
                        KIND_K: begin
                            if (!isComma) begin
                                frameErr_d = 1'b1;
                                state_d    = UNLOCKED;
                                commaCnt_d = 4'd0;
                            end
                        end
                        KIND_SOP: begin
                            channel_d = rxByte[1:0];
                            byteCnt_d = '0;
                            state_d   = FRAME;
                        end
                        default: frameErr_d = 1'b1;
                    endcase
                end
                FRAME: begin
                    case (kind)
                        KIND_DATA: begin
                            // The byte beyond MAX_LEN is dropped and the frame aborted.
                            if (byteCnt_q == LEN_MAX) begin
                                frameErr_d = 1'b1;
                                state_d    = IDLE;
                            end else begin
                                dataOut_d   = rxByte;
                                dataValid_d = 4'b0001 << channel_q;
                                byteCnt_d   = byteCnt_q + 1'b1;
                            end
                        end
                        KIND_EOP: begin
                            frameEnd_d = 4'b0001 << channel_q;
                            state_d    = IDLE;
                        end
                        KIND_SOP: begin
                            // A new SOP aborts the open frame and starts a fresh one.
                            frameErr_d = 1'b1;
                            channel_d  = rxByte[1:0];
                            byteCnt_d  = '0;
                        end
                        default: begin
                            if (!isComma) begin
                                frameErr_d = 1'b1;
                                state_d    = UNLOCKED;
                                commaCnt_d = 4'd0;
                            end
                        end
                    endcase
                end
                default: begin
                    state_d    = UNLOCKED;
                    commaCnt_d = 4'd0;
                end
            endcase
        end
        locked_d = (state_d != UNLOCKED);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= UNLOCKED;
            commaCnt_q  <= 4'd0;
            byteCnt_q   <= '0;
            channel_q   <= 2'd0;
            dataOut_q   <= 8'h00;
            dataValid_q <= 4'b0000;
            frameEnd_q  <= 4'b0000;
            frameErr_q  <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            commaCnt_q  <= commaCnt_d;
            byteCnt_q   <= byteCnt_d;
            channel_q   <= channel_d;
            dataOut_q   <= dataOut_d;
            dataValid_q <= dataValid_d;
            frameEnd_q  <= frameEnd_d;
            frameErr_q  <= frameErr_d;
            locked_q    <= locked_d;
        end
    end

    assign bus.data_out   = dataOut_q;
    assign bus.data_valid = dataValid_q;
    assign bus.frame_end  = frameEnd_q;
    assign bus.frame_err  = frameErr_q;
    assign bus.locked     = locked_q;

`ifdef ELINK_RX_ERRCNT_EN
    logic [7:0] errCount_q, errCount_d;

    // Error counter follows the frame_err pulse and saturates at 8'hFF.
    always_comb begin
        errCount_d = errCount_q;
        if (frameErr_d && (errCount_q != 8'hFF)) begin
            errCount_d = errCount_q + 8'd1;
        end
    end

    // Error counter register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            errCount_q <= 8'h00;
        end else begin
            errCount_q <= errCount_d;
        end
    end

    assign bus.err_count = errCount_q;
`endif

endmodule

// File: tb/tb_elink_rx_distributor.sv
// tb_elink_rx_distributor
// Randomized and directed stimulus for elink_rx_distributor with a
// behavioural reference model. Each driven cycle pushes the expected
// registered outputs into a queue; an independent monitor pops and compares
// one entry per clock after the DUT registers the word.
module tb_elink_rx_distributor;

    localparam int LOCK = 4;
    localparam int MAXL = 16;
    localparam logic [7:0] COMMA = 8'hBC;

    typedef struct {
        logic [3:0] dv;
        logic [3:0] fe;
        logic       err;
        logic       lk;
        logic [7:0] dout;
        logic       chkDout;
        logic [7:0] ec;
    } exp_t;

    logic clk;
    logic rst;
    elink_rx_distributor_if bus();

    elink_rx_distributor #(.LOCK_CNT(LOCK), .MAX_LEN(MAXL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: lock flag, comma run, open frame, channel, length.
    bit       mLocked = 0;
    int       mRun    = 0;
    bit       mInFrame = 0;
    int       mCh     = 0;
    int       mCnt    = 0;
    int       mErrCnt = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: applies the framing rules to one driven word and
    // returns the outputs the DUT should show one clock later.
    task automatic modelStep(input logic v, input logic [9:0] w, output exp_t e);
        logic [1:0] k;
        logic [7:0] b;
        bit comma;
        e.dv = 4'b0; e.fe = 4'b0; e.err = 1'b0; e.dout = 8'h00; e.chkDout = 1'b0;
        k = w[9:8];
        b = w[7:0];
        comma = (k == 2'b11) && (b == COMMA);
        if (v) begin
            if (!mLocked) begin
                if (comma) begin
                    mRun++;
                    if (mRun == LOCK) begin
                        mLocked = 1; mRun = 0; mInFrame = 0;
                    end
                end else begin
                    mRun = 0;
                end
            end else if (k == 2'b11 && !comma) begin
                e.err = 1'b1; mLocked = 0; mRun = 0; mInFrame = 0;
            end else if (comma) begin
                // filler
            end else if (k == 2'b01) begin
                if (mInFrame) e.err = 1'b1;
                mInFrame = 1; mCh = int'(b[1:0]); mCnt = 0;
            end else if (!mInFrame) begin
                e.err = 1'b1;
            end else if (k == 2'b10) begin
                e.fe = 4'(1 << mCh); mInFrame = 0;
            end else if (mCnt == MAXL) begin
                e.err = 1'b1; mInFrame = 0;
            end else begin
                e.dv = 4'(1 << mCh); e.dout = b; e.chkDout = 1'b1; mCnt++;
            end
        end
        if (e.err && mErrCnt < 255) mErrCnt++;
        e.lk = mLocked;
        e.ec = 8'(mErrCnt);
    endtask

    // Drive one word (or an idle cycle) at the falling edge and queue its expectation.
    task automatic applyStimulus(input logic v, input logic [9:0] w);
        exp_t e;
        @(negedge clk);
        rst = 1'b1;
        bus.data_rx_valid = v;
        bus.data_rx_in = w;
        modelStep(v, w, e);
        expQ.push_back(e);
    endtask

    task automatic applyReset();
        exp_t e;
        @(negedge clk);
        rst = 1'b0;
        bus.data_rx_valid = 1'b0;
        bus.data_rx_in = 10'h000;
        mLocked = 0; mRun = 0; mInFrame = 0; mCh = 0; mCnt = 0; mErrCnt = 0;
        e.dv = 4'b0; e.fe = 4'b0; e.err = 1'b0; e.lk = 1'b0;
        e.dout = 8'h00; e.chkDout = 1'b1; e.ec = 8'h00;
        expQ.push_back(e);
    endtask

    task automatic sendComma(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, {2'b11, COMMA});
    endtask

    // Monitor: shortly after each rising edge, pop the expectation for the
    // word registered on that edge and compare all outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("data_valid", 32'(bus.data_valid), 32'(e.dv));
                checkOutput("frame_end", 32'(bus.frame_end), 32'(e.fe));
                checkOutput("frame_err", 32'(bus.frame_err), 32'(e.err));
                checkOutput("locked", 32'(bus.locked), 32'(e.lk));
                if (e.chkDout) checkOutput("data_out", 32'(bus.data_out), 32'(e.dout));
`ifdef ELINK_RX_ERRCNT_EN
                checkOutput("err_count", 32'(bus.err_count), 32'(e.ec));
`endif
            end
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        int r;
        int budget;
        logic [7:0] b;
        rst = 1'b0;
        bus.data_rx_valid = 1'b0;
        bus.data_rx_in = 10'h000;
        bus.Kchar_comma = COMMA;

        applyReset();
        applyReset();

        // Lock acquisition with an interrupted comma run.
        sendComma(3);
        applyStimulus(1'b1, {2'b00, 8'h00});
        sendComma(4);
        applyStimulus(1'b0, 10'h000);

        // Frame routed to channel 2.
        applyStimulus(1'b1, {2'b01, 8'h02});
        applyStimulus(1'b1, {2'b00, 8'h11});
        applyStimulus(1'b1, {2'b00, 8'h22});
        applyStimulus(1'b1, {2'b10, 8'h00});

        // Length limit on channel 1, then an EOP while idle.
        applyStimulus(1'b1, {2'b01, 8'h01});
        for (int i = 0; i < MAXL + 1; i++) applyStimulus(1'b1, {2'b00, 8'(8'h40 + i)});
        applyStimulus(1'b1, {2'b10, 8'h00});

        // Filler and gaps inside a frame on channel 3; SOP upper bits ignored.
        applyStimulus(1'b1, {2'b01, 8'hFF});
        applyStimulus(1'b1, {2'b11, COMMA});
        applyStimulus(1'b0, {2'b00, 8'h77});
        applyStimulus(1'b0, {2'b00, 8'h66});
        applyStimulus(1'b1, {2'b00, 8'hA5});
        applyStimulus(1'b1, {2'b10, 8'h00});

        // Empty frame, then SOP inside a frame.
        applyStimulus(1'b1, {2'b01, 8'h00});
        applyStimulus(1'b1, {2'b10, 8'h00});
        applyStimulus(1'b1, {2'b01, 8'h00});
        applyStimulus(1'b1, {2'b01, 8'h03});
        applyStimulus(1'b1, {2'b00, 8'h3C});
        applyStimulus(1'b1, {2'b10, 8'h00});

        // Illegal K-char mid-frame drops lock until 4 commas are seen.
        applyStimulus(1'b1, {2'b01, 8'h00});
        applyStimulus(1'b1, {2'b00, 8'h01});
        applyStimulus(1'b1, {2'b11, 8'h1C});
        applyStimulus(1'b1, {2'b00, 8'h99});
        applyStimulus(1'b1, {2'b01, 8'h01});
        sendComma(4);

        // Reset in the middle of a frame.
        applyStimulus(1'b1, {2'b01, 8'h02});
        applyStimulus(1'b1, {2'b00, 8'h55});
        applyReset();
        applyStimulus(1'b1, {2'b00, 8'h12});
        applyStimulus(1'b1, {2'b01, 8'h02});
        applyStimulus(1'b1, {2'b00, 8'h34});

        // Randomized traffic, biased toward commas while unlocked.
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            b = 8'($urandom);
            if (!mLocked && r < 70) begin
                applyStimulus(1'b1, {2'b11, COMMA});
            end else if (r < 8) begin
                applyStimulus(1'b0, {2'($urandom), b});
            end else if (r < 20) begin
                applyStimulus(1'b1, {2'b11, COMMA});
            end else if (r < 30) begin
                applyStimulus(1'b1, {2'b01, b});
            end else if (r < 78) begin
                applyStimulus(1'b1, {2'b00, b});
            end else if (r < 90) begin
                applyStimulus(1'b1, {2'b10, b});
            end else if (r < 94) begin
                if (b == COMMA) b = 8'h1C;
                applyStimulus(1'b1, {2'b11, b});
            end else if (r < 95) begin
                applyReset();
            end else begin
                applyStimulus(1'b1, {2'b11, COMMA});
            end
        end

        applyStimulus(1'b0, 10'h000);
        applyStimulus(1'b0, 10'h000);

        // Let the monitor drain the queue within a bounded number of cycles.
        budget = 0;
        while (expQ.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #2;
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
